// File: rtl/mx_block_requant.sv
// MX block requantiser: gathers K (mantissa, exponent) elements, aligns them to the
// block's max exponent and renormalises the mantissas to MAN_WIDTH+1 signed bits.

module mx_block_requant_lane #(
    parameter int IN_WIDTH    = 32,
    parameter int SCALE_WIDTH = 8,
    parameter int OUT_W       = 9,
    parameter int WW          = 6
) (
    input  logic [IN_WIDTH-1:0]    m,
    input  logic [SCALE_WIDTH-1:0] e,
    input  logic [SCALE_WIDTH-1:0] emax,
    input  logic [IN_WIDTH-1:0]    a,
    input  logic [WW-1:0]          r,
    output logic [IN_WIDTH-1:0]    a_nxt,
    output logic [WW-1:0]          w,
    output logic [OUT_W-1:0]       q
);
    logic [SCALE_WIDTH-1:0] sh;
    logic [IN_WIDTH-1:0]    mag;
    logic [IN_WIDTH-1:0]    a_rs;

    assign sh = emax - e;

    // Shifts past the word leave only sign fill.
    always_comb begin
        if (32'(sh) >= 32'(IN_WIDTH))
            a_nxt = {IN_WIDTH{m[IN_WIDTH-1]}};
        else
            a_nxt = $signed(m) >>> sh;
    end

    // Minimum signed width: highest bit that differs from the sign, plus the sign.
    assign mag = a[IN_WIDTH-1] ? ~a : a;
    always_comb begin
        w = WW'(1);
        for (int i = 0; i < IN_WIDTH; i++)
            if (mag[i]) w = WW'(i + 2);
    end

    assign a_rs = $signed(a) >>> r;
    assign q    = a_rs[OUT_W-1:0];
endmodule

module mx_block_requant #(
    parameter int K           = 2,
    parameter int IN_WIDTH    = 32,
    parameter int MAN_WIDTH   = 8,
    parameter int SCALE_WIDTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_data_valid,
    output logic                           o_data_ready,
    input  logic [IN_WIDTH-1:0]            i_data,
    input  logic [SCALE_WIDTH-1:0]         i_scale,
    output logic                           o_blk_valid,
    input  logic                           i_blk_ready,
    output logic [K-1:0][MAN_WIDTH:0]      o_blk_data,
    output logic [SCALE_WIDTH-1:0]         o_blk_scale,
    output logic                           o_blk_ovf
);
    localparam int OUT_W = MAN_WIDTH + 1;
    localparam int CNT_W = $clog2(K);
    localparam int WW    = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {COLLECT, ALIGN, NORM, EMIT} state_t;

    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic [SCALE_WIDTH-1:0]        emax;
    logic [K-1:0][IN_WIDTH-1:0]    m_q;
    logic [K-1:0][IN_WIDTH-1:0]    a_q;
    logic [K-1:0][IN_WIDTH-1:0]    a_nxt;
    logic [K-1:0][SCALE_WIDTH-1:0] e_q;
    logic [K-1:0][WW-1:0]          w;
    logic [K-1:0][OUT_W-1:0]       q;
    logic [WW-1:0]                 r;
    logic [SCALE_WIDTH:0]          e_out;
    logic                          accept;

    assign accept = i_data_valid & o_data_ready;

    genvar g;
    generate
        for (g = 0; g < K; g++) begin : g_lane
            mx_block_requant_lane #(
                .IN_WIDTH   (IN_WIDTH),
                .SCALE_WIDTH(SCALE_WIDTH),
                .OUT_W      (OUT_W),
                .WW         (WW)
            ) u_lane (
                .m    (m_q[g]),
                .e    (e_q[g]),
                .emax (emax),
                .a    (a_q[g]),
                .r    (r),
                .a_nxt(a_nxt[g]),
                .w    (w[g]),
                .q    (q[g])
            );
        end
    endgenerate

    // Block-wide renormalisation shift: enough to fit the widest aligned element.
    always_comb begin
        r = '0;
        for (int i = 0; i < K; i++)
            if (int'(w[i]) - OUT_W > int'(r)) r = WW'(int'(w[i]) - OUT_W);
    end

    assign e_out = {1'b0, emax} + (SCALE_WIDTH+1)'(r);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= COLLECT;
            cnt          <= '0;
            emax         <= '0;
            m_q          <= '0;
            e_q          <= '0;
            a_q          <= '0;
            o_data_ready <= 1'b1;
            o_blk_valid  <= 1'b0;
            o_blk_data   <= '0;
            o_blk_scale  <= '0;
            o_blk_ovf    <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        m_q[cnt] <= i_data;
                        e_q[cnt] <= i_scale;
                        if (i_scale > emax) emax <= i_scale;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(K - 1)) begin
                            cnt          <= '0;
                            o_data_ready <= 1'b0;
                            state        <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    a_q   <= a_nxt;
                    state <= NORM;
                end
                NORM: begin
                    o_blk_data <= q;
                    if (e_out[SCALE_WIDTH]) begin
                        o_blk_scale <= '1;
                        o_blk_ovf   <= 1'b1;
                    end else begin
                        o_blk_scale <= e_out[SCALE_WIDTH-1:0];
                        o_blk_ovf   <= 1'b0;
                    end
                    o_blk_valid <= 1'b1;
                    state       <= EMIT;
                end
                EMIT: begin
                    if (i_blk_ready) begin
                        o_blk_valid  <= 1'b0;
                        o_data_ready <= 1'b1;
                        emax         <= '0;
                        state        <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_mx_block_requant.sv
// Randomised and directed bench for mx_block_requant against an arithmetic
// reference model (floor division by powers of two, min signed width search).

module tb_mx_block_requant;
    localparam int K           = 2;
    localparam int IN_WIDTH    = 32;
    localparam int MAN_WIDTH   = 8;
    localparam int SCALE_WIDTH = 8;

    logic                      i_clk;
    logic                      i_rst_n;
    logic                      i_data_valid;
    logic                      o_data_ready;
    logic [IN_WIDTH-1:0]       i_data;
    logic [SCALE_WIDTH-1:0]    i_scale;
    logic                      o_blk_valid;
    logic                      i_blk_ready;
    logic [K-1:0][MAN_WIDTH:0] o_blk_data;
    logic [SCALE_WIDTH-1:0]    o_blk_scale;
    logic                      o_blk_ovf;

    mx_block_requant #(
        .K(K), .IN_WIDTH(IN_WIDTH), .MAN_WIDTH(MAN_WIDTH), .SCALE_WIDTH(SCALE_WIDTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready),
        .i_data      (i_data),
        .i_scale     (i_scale),
        .o_blk_valid (o_blk_valid),
        .i_blk_ready (i_blk_ready),
        .o_blk_data  (o_blk_data),
        .o_blk_scale (o_blk_scale),
        .o_blk_ovf   (o_blk_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // floor(x / 2^sh)
    function automatic longint fdiv(input longint x, input int sh);
        longint d, qv;
        if (sh >= 40) return (x < 0) ? -1 : 0;
        d  = longint'(1) << sh;
        qv = x / d;
        if (x < 0 && (x % d) != 0) qv = qv - 1;
        return qv;
    endfunction

    function automatic int min_w(input longint a);
        for (int n = 1; n < 63; n++) begin
            longint lim;
            lim = longint'(1) << (n - 1);
            if (a >= -lim && a <= lim - 1) return n;
        end
        return 63;
    endfunction

    function automatic void model(input longint mv[K], input int ev[K],
                                  output longint qv[K], output int sc, output int ov);
        longint a[K];
        int emx, rr, eo;
        emx = 0;
        for (int i = 0; i < K; i++) if (ev[i] > emx) emx = ev[i];
        rr = 0;
        for (int i = 0; i < K; i++) begin
            a[i] = fdiv(mv[i], emx - ev[i]);
            if (min_w(a[i]) - (MAN_WIDTH + 1) > rr) rr = min_w(a[i]) - (MAN_WIDTH + 1);
        end
        for (int i = 0; i < K; i++) qv[i] = fdiv(a[i], rr);
        eo = emx + rr;
        if (eo > (1 << SCALE_WIDTH) - 1) begin sc = (1 << SCALE_WIDTH) - 1; ov = 1; end
        else begin sc = eo; ov = 0; end
    endfunction

    task automatic push(input longint m, input int e);
        int n;
        n = 0;
        i_data       = IN_WIDTH'(m);
        i_scale      = SCALE_WIDTH'(e);
        i_data_valid = 1'b1;
        while (!o_data_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk("push_ready", o_data_ready, 1);
        @(posedge i_clk);
        #1;
        i_data_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input longint qv[K], input int sc, input int ov);
        for (int i = 0; i < K; i++)
            chk($sformatf("%s_d%0d", tag, i), longint'($signed(o_blk_data[i])), qv[i]);
        chk({tag, "_scale"}, longint'(o_blk_scale), sc);
        chk({tag, "_ovf"}, longint'(o_blk_ovf), ov);
    endtask

    task automatic run_block(input string tag, input longint mv[K], input int ev[K], input int bp);
        longint qv[K];
        int sc, ov;
        model(mv, ev, qv, sc, ov);
        for (int i = 0; i < K; i++) push(mv[i], ev[i]);
        chk({tag, "_t0_valid"}, o_blk_valid, 0);
        chk({tag, "_t0_ready"}, o_data_ready, 0);
        @(posedge i_clk); #1;
        chk({tag, "_t1_valid"}, o_blk_valid, 0);
        @(posedge i_clk); #1;
        chk({tag, "_t2_valid"}, o_blk_valid, 1);
        check_out(tag, qv, sc, ov);
        for (int c = 0; c < bp; c++) begin
            i_data_valid = 1'b1;
            i_data       = $urandom;
            i_scale      = SCALE_WIDTH'($urandom);
            @(posedge i_clk); #1;
            chk({tag, "_bp_ready"}, o_data_ready, 0);
            chk({tag, "_bp_valid"}, o_blk_valid, 1);
            check_out({tag, "_bp"}, qv, sc, ov);
        end
        i_data_valid = 1'b0;
        i_blk_ready  = 1'b1;
        @(posedge i_clk); #1;
        i_blk_ready = 1'b0;
        chk({tag, "_hs_valid"}, o_blk_valid, 0);
        chk({tag, "_hs_ready"}, o_data_ready, 1);
    endtask

    task automatic blk2(input string tag, input longint m0, input int e0,
                        input longint m1, input int e1, input int bp);
        longint mv[K];
        int ev[K];
        mv[0] = m0; ev[0] = e0;
        mv[1] = m1; ev[1] = e1;
        run_block(tag, mv, ev, bp);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, o_data_ready, 1);
        chk({tag, "_valid"}, o_blk_valid, 0);
        for (int i = 0; i < K; i++)
            chk($sformatf("%s_d%0d", tag, i), longint'(o_blk_data[i]), 0);
        chk({tag, "_scale"}, longint'(o_blk_scale), 0);
        chk({tag, "_ovf"}, longint'(o_blk_ovf), 0);
    endtask

    initial begin
        longint mv[K];
        int ev[K];
        int base, bits;
        logic signed [31:0] raw;

        i_rst_n = 1'b0; i_data_valid = 1'b0; i_blk_ready = 1'b0;
        i_data = '0; i_scale = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_vals("rst0");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        blk2("eq_fit",   100, 5,   -3, 5,   0);
        blk2("align_a",   64, 10,  64, 7,   0);
        blk2("align_b",   -5, 0,    1, 40,  0);
        blk2("renorm_a", 1000, 2, -1000, 2, 0);
        blk2("renorm_b",  256, 0, -257, 0,  0);
        blk2("clamp",  1 << 20, 250, 0, 250, 0);
        blk2("bp",        100, 5,   -3, 5,  10);
        blk2("after_bp",  -77, 3,  500, 1,  0);

        // Async reset mid-collect with a non-zero block still on the outputs.
        push(123, 4);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("rst_collect");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        blk2("post_rst", -9, 6, 40, 2, 0);

        // Async reset while a block is pending in EMIT.
        push(55, 1);
        push(-66, 9);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        chk("rst_emit_pre_valid", o_blk_valid, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("rst_emit");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_emit_no_pulse", o_blk_valid, 0);
        blk2("post_rst2", 3, 0, -4, 0, 0);

        for (int b = 0; b < 60; b++) begin
            base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(240, 255))
                                               : int'($urandom_range(0, 255));
            for (int i = 0; i < K; i++) begin
                bits  = $urandom_range(1, 32);
                raw   = $urandom;
                mv[i] = longint'(raw >>> (32 - bits));
                ev[i] = base - int'($urandom_range(0, (base < 40) ? base : 40));
            end
            run_block($sformatf("rnd%0d", b), mv, ev, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
